countdown_timer: RTL
====================

// Module: countdown_timer
// PURPOSE
//   Loadable down-counter with a programmable prescaler. The CPU loads a
//   value, starts it, and receives a one-cycle done pulse when the count
//   expires. Used as the feed-interval / dispense-duration timer.
//   It counts down where the existing up-counter counts up, and it adds a
//   start/done handshake around the count.
// PARAMETERS
//   WIDTH       6   width of the count value
//   PRESCALE_W  16  width of the prescaler compare value
// PORTS
//   clk          in   1           system clock, rising edge
//   clr          in   1           reset, asynchronous, active-high
//   load         in   1           capture load_val into reload_reg and count
//   load_val     in   WIDTH       value to load
//   start        in   1           begin counting (honoured in IDLE only)
//   pause        in   1           hold count and prescaler while high
//   auto_reload  in   1           on expiry, reload from reload_reg and keep running
//   prescale     in   PRESCALE_W  clock cycles per decrement = prescale+1
//   count        out  WIDTH       current count value
//   busy         out  1           high while state==RUN
//   done         out  1           one-cycle pulse on expiry
//   zero         out  1           combinational: count==0
// BEHAVIOUR
//   - clr high (async): count=0, reload_reg=0, presc_cnt=0, state=IDLE,
//     busy=0, done=0. Outputs stay at these values until the first clk edge
//     after clr falls.
//   - Priority on each edge: clr > load > start > run logic.
//     done defaults to 0 on every edge unless set below.
//   - load (any state): count<=load_val, reload_reg<=load_val, presc_cnt<=0,
//     state<=IDLE. A load while RUN aborts the run and does not pulse done.
//   - IDLE + start + count!=0: state<=RUN, presc_cnt<=0.
//   - IDLE + start + count==0: done<=1 for one cycle; state stays IDLE;
//     busy never rises.
//   - RUN + start: ignored.
//   - RUN + pause: all state holds; done is not generated.
//   - RUN, not paused, presc_cnt < prescale: presc_cnt<=presc_cnt+1.
//   - RUN, not paused, presc_cnt >= prescale: presc_cnt<=0 and count steps.
//     The >= comparison makes a mid-run decrease of prescale safe.
//     * count>1: count<=count-1.
//     * count==1, auto_reload=0: count<=0, done<=1, state<=IDLE.
//     * count==1, auto_reload=1, reload_reg!=0: count<=reload_reg,
//       done<=1, state stays RUN (0 never appears on count).
//     * count==1, auto_reload=1, reload_reg==0: count<=0, done<=1,
//       state<=IDLE.
//   - Latency: start sampled at edge t0 -> done is high in the cycle after
//     edge t0 + N*(prescale+1), with N the count at start and no pause.
//     Each paused cycle adds one cycle.
//   - No wrap-around: count never decrements below 0.
//   - done and busy are registered; zero is combinational from count.
// STRUCTURE
//   - timer_defs.vh: state encodings ST_IDLE=1'b0, ST_RUN=1'b1.
//   - Sub-module tick_gen (prescaler): inputs clk, clr, en, sync_clr,
//     prescale; output tick, high when presc_cnt >= prescale && en.
//     sync_clr (asserted on load or start) zeroes presc_cnt.
//   - The top level holds the FSM, count register, reload_reg and done flop.
// TESTING
//   1. load 5, prescale 0, start -> count 5,4,3,2,1,0 on consecutive edges;
//      done=1 for exactly the one cycle count first reads 0; busy falls at
//      that same edge.
//   2. load 2, prescale 3, start -> done high in the cycle after edge t0+8;
//      count changes only every 4th edge.
//   3. load 4, prescale 0, start, pause high for 3 cycles after 2nd
//      decrement -> done delayed by exactly 3 cycles; count holds at 2.
//   4. load 3, auto_reload 1, prescale 0, start -> count 3,2,1,3,2,1,...;
//      done pulses every 3 cycles; busy stays high; zero never asserts.
//   5. count 0, start -> single done pulse next cycle, busy stays 0.
//      Next: load 6 and start, then load 9 mid-run -> state IDLE, count=9,
//      no done pulse.
//   6. clr asserted asynchronously mid-run (between edges) -> count=0,
//      busy=0, done=0 immediately. After release, start with count 0
//      behaves as in test 5.

Source files
------------

// File: rtl/countdown_timer_pkg.sv
// Shared types for the countdown timer: FSM state and the step taken on a tick.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package countdown_timer_pkg;

  // FSM encoding: the timer is either parked or counting.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Action applied to the count when a prescaler tick lands in RUN.
  typedef enum logic [1:0] {
    STEP_DEC    = 2'd0,  // ordinary decrement, not yet at the last unit
    STEP_RELOAD = 2'd1,  // last unit with auto-reload armed: restart from reload_reg
    STEP_EXPIRE = 2'd2   // last unit, run ends at zero
  } step_t;

  // Decide what a tick does. A reload value of zero cannot restart the run,
  // so it falls back to a normal expiry rather than parking RUN on count 0.
  function automatic step_t classify_step(input logic last_unit,
                                          input logic auto_rl,
                                          input logic reload_nonzero);
    if (!last_unit) begin
      return STEP_DEC;
    end
    if (auto_rl && reload_nonzero) begin
      return STEP_RELOAD;
    end
    return STEP_EXPIRE;
  endfunction

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// Prescaler for the countdown timer: emits one tick every prescale+1 enabled cycles.
// Latency: tick is combinational from the registered prescaler count and en.
// Backpressure: none; deasserting en freezes the prescaler in place.
//
// Ports:
//   clk       system clock, rising edge
//   clr       asynchronous active-high reset, zeroes the prescaler
//   en        advance the prescaler this cycle (RUN and not paused)
//   sync_clr  synchronous restart of the prescaler (load or accepted start)
//   prescale  compare value; a tick fires once the count reaches it
//   tick      high on the cycle the count should step
module tick_gen #(
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  sync_clr,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] presc_cnt;
  logic                  at_limit;

  // >= rather than == so that lowering prescale mid-run cannot strand the
  // counter above the new limit and make it wrap all the way around.
  assign at_limit = (presc_cnt >= prescale);
  assign tick     = en && at_limit;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      presc_cnt <= '0;
    end else if (sync_clr) begin
      presc_cnt <= '0;
    end else if (en) begin
      if (at_limit) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, start/busy handshake and a one-cycle done pulse.
// Latency: start at edge t0 -> done high after edge t0 + N*(prescale+1) (+1 per paused cycle).
// Backpressure: pause freezes count and prescaler; start is ignored while busy.
//
// Ports:
//   clk          system clock, rising edge
//   clr          asynchronous active-high reset
//   load         capture load_val into both the count and the reload register
//   load_val     value to load
//   start        begin counting (only honoured when idle)
//   pause        hold count and prescaler while high
//   auto_reload  on expiry restart from the reload register instead of stopping
//   prescale     clock cycles per decrement minus one
//   count        current count value
//   busy         high while running
//   done         one-cycle pulse on expiry
//   zero         combinational count == 0
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH      = 6,
  parameter int PRESCALE_W = 16
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] reload_nxt;
  logic             done_nxt;
  logic             busy_nxt;

  logic             start_ok;
  logic             run_en;
  logic             sync_clr;
  logic             tick;
  step_t            step;

  // A start while running must not restart the prescaler, so only an
  // accepted (idle) start counts as a restart request.
  assign start_ok = (state == ST_IDLE) && start;
  assign run_en   = (state == ST_RUN) && !pause;
  assign sync_clr = load || start_ok;

  // In RUN the count is always >= 1, so "<= 1" identifies the final unit;
  // it also keeps a corrupted zero from ever decrementing through 0.
  assign step = classify_step(count <= ONE, auto_reload, reload_reg != '0);

  tick_gen #(
    .PRESCALE_W(PRESCALE_W)
  ) u_tick_gen (
    .clk      (clk),
    .clr      (clr),
    .en       (run_en),
    .sync_clr (sync_clr),
    .prescale (prescale),
    .tick     (tick)
  );

  // Next-state and datapath. Priority: load > start > run logic.
  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    reload_nxt = reload_reg;
    done_nxt   = 1'b0;

    if (load) begin
      // Aborts any run silently; no done for an interrupted count.
      count_nxt  = load_val;
      reload_nxt = load_val;
      state_nxt  = ST_IDLE;
    end else if (start_ok) begin
      if (count != '0) begin
        state_nxt = ST_RUN;
      end else begin
        // Nothing to count: report expiry straight away, never go busy.
        done_nxt = 1'b1;
      end
    end else if ((state == ST_RUN) && tick) begin
      case (step)
        STEP_DEC: begin
          count_nxt = count - ONE;
        end
        STEP_RELOAD: begin
          // Jump straight to the reload value so 0 never shows on count.
          count_nxt = reload_reg;
          done_nxt  = 1'b1;
        end
        default: begin
          count_nxt = '0;
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end
      endcase
    end

    busy_nxt = (state_nxt == ST_RUN);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state      <= ST_IDLE;
      count      <= '0;
      reload_reg <= '0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      reload_reg <= reload_nxt;
      done       <= done_nxt;
      busy       <= busy_nxt;
    end
  end

  assign zero = (count == '0);

endmodule
